// File: rtl/sumador_serial.sv
// Bit-serial adder: feeds the sumadorOneBit full-adder cell one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SUMADOR_SERIAL_OVF_EN.

module sumadorOneBit (
   input  logic A,
   input  logic B,
   input  logic Ci,
   output logic Co,
   output logic So
);

   assign So = A ^ B ^ Ci;
   assign Co = (A & B) | (Ci & (A ^ B));

endmodule

module sumador_serial #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             Co
`ifdef SUMADOR_SERIAL_OVF_EN
   ,
   output logic             OVF
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t r_state;
   state_t w_nextState;

   logic [WIDTH-1:0] r_aSh;
   logic [WIDTH-1:0] r_bSh;
   logic [WIDTH-1:0] r_sumSh;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_co;
   logic [CW-1:0]    r_count;

   logic w_so;
   logic w_co;
   logic w_accept;
   logic w_last;

   sumadorOneBit u_fullAdder (
      .A  (r_aSh[0]),
      .B  (r_bSh[0]),
      .Ci (r_carry),
      .Co (w_co),
      .So (w_so)
   );

   assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_last   = (r_state == RUN) && (r_count == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_nextState = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (w_last) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
            w_nextState = start ? RUN : IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Sum bits enter from the MSB side so that after WIDTH shifts bit 0 lands at the LSB.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_aSh   <= '0;
         r_bSh   <= '0;
         r_sumSh <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_co    <= 1'b0;
         r_count <= '0;
      end else if (w_accept) begin
         r_aSh   <= A;
         r_bSh   <= B;
         r_carry <= Ci;
         r_count <= '0;
      end else if (r_state == RUN) begin
         r_aSh   <= r_aSh >> 1;
         r_bSh   <= r_bSh >> 1;
         r_sumSh <= {w_so, r_sumSh[WIDTH-1:1]};
         r_carry <= w_co;
         r_count <= r_count + 1'b1;
         if (w_last) begin
            r_sum <= {w_so, r_sumSh[WIDTH-1:1]};
            r_co  <= w_co;
         end
      end
   end

   assign S  = r_sum;
   assign Co = r_co;

`ifdef SUMADOR_SERIAL_OVF_EN
   logic r_ovf;

   // During the last RUN cycle the carry FF holds the carry into the MSB.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (w_last && !w_accept) begin
         r_ovf <= r_carry ^ w_co;
      end
   end

   assign OVF = r_ovf;
`endif

endmodule
